// File: rtl/measure_pkg.sv
// Shared constants and state encoding for the DAC write path.
package measure_pkg;

   localparam int         DAC_CODE_WIDTH = 16;
   localparam int         DAC_DATA_WIDTH = 24;
   localparam logic [7:0] DAC_CMD        = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_ACK       = 3'd4
   } dac_arb_state_t;

   // Index following idx, wrapping back to 0 at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, searching upward and wrapping modulo N_REQ.
module rr_arbiter #(
   parameter  int N_REQ = 3,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] grant_o,
   output logic             valid_o
);

   // Scan N_REQ positions starting at the pointer; keep the first hit.
   always_comb begin
      int idx;
      grant_o = '0;
      valid_o = 1'b0;
      idx     = 0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = (int'(ptr_i) + off) % N_REQ;
         if (req_i[idx] && !valid_o) begin
            valid_o = 1'b1;
            grant_o = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/dac_write_arbiter.sv
// Arbitrates DAC threshold writes from several requesters onto one SPI
// master: latches the winning code, strobes one write, tracks the SPI
// busy/ready handshake with a per-phase timeout, and acks the requester.
module dac_write_arbiter
   import measure_pkg::*;
#(
   parameter  int         N_REQ          = 3,
   parameter  int         CODE_WIDTH     = DAC_CODE_WIDTH,
   parameter  int         DATA_WIDTH     = DAC_DATA_WIDTH,
   parameter  logic [7:0] DAC_CMD        = measure_pkg::DAC_CMD,
   parameter  int         TIMEOUT_CYCLES = 1024,
   localparam int         SRC_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                        clk_i,
   input  logic                        arst_ni,
   input  logic [N_REQ-1:0]            req_i,
   input  logic [N_REQ*CODE_WIDTH-1:0] code_i,
   output logic [N_REQ-1:0]            ack_o,
   output logic                        busy_o,
   output logic [DATA_WIDTH-1:0]       spi_data_o,
   output logic                        spi_wre_o,
   input  logic                        spi_rdy_i,
   output logic [CODE_WIDTH-1:0]       last_code_o,
   output logic [SRC_W-1:0]            last_src_o,
   output logic                        timeout_err_o,
   input  logic                        err_clr_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   // Command byte in the top bits, code in the bottom bits, zeros between.
   function automatic logic [DATA_WIDTH-1:0] build_frame(input logic [CODE_WIDTH-1:0] code);
      logic [DATA_WIDTH-1:0] f;
      f                     = '0;
      f[DATA_WIDTH-1 -: 8]  = DAC_CMD;
      f[CODE_WIDTH-1:0]     = code;
      return f;
   endfunction

   dac_arb_state_t        state_q, state_d;
   logic [SRC_W-1:0]      grant_q, grant_d;
   logic [SRC_W-1:0]      ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CODE_WIDTH-1:0] last_code_q, last_code_d;
   logic [SRC_W-1:0]      last_src_q, last_src_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [SRC_W-1:0]      arb_grant;
   logic                  arb_valid;
   logic                  phase_expired;
   logic                  timeout_hit;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr_arbiter (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .valid_o (arb_valid)
   );

   // The current wait phase has used up its cycle budget.
   assign phase_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Next-state, grant/pointer/frame latching, completion and error logic.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      data_d      = data_q;
      last_code_d = last_code_q;
      last_src_d  = last_src_q;
      err_d       = err_q;
      cnt_d       = '0;
      timeout_hit = 1'b0;

      if (err_clr_i) begin
         err_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid && spi_rdy_i) begin
               state_d = ST_LAUNCH;
               grant_d = arb_grant;
               ptr_d   = SRC_W'(rr_next(int'(arb_grant), N_REQ));
               data_d  = build_frame(code_i[int'(arb_grant)*CODE_WIDTH +: CODE_WIDTH]);
            end
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!spi_rdy_i) begin
               state_d = ST_WAIT_DONE;
            end else if (phase_expired) begin
               state_d     = ST_ACK;
               timeout_hit = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (spi_rdy_i) begin
               state_d     = ST_ACK;
               last_code_d = data_q[CODE_WIDTH-1:0];
               last_src_d  = grant_q;
            end else if (phase_expired) begin
               state_d     = ST_ACK;
               timeout_hit = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A fresh timeout overrides a clear arriving in the same cycle.
      if (timeout_hit) begin
         err_d = 1'b1;
      end
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         data_q      <= build_frame('0);
         last_code_q <= '0;
         last_src_q  <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         data_q      <= data_d;
         last_code_q <= last_code_d;
         last_src_q  <= last_src_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // One-hot ack for the granted requester, only while in ACK.
   always_comb begin
      ack_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         ack_o[i] = (state_q == ST_ACK) && (grant_q == SRC_W'(i));
      end
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign spi_wre_o     = (state_q == ST_LAUNCH);
   assign spi_data_o    = data_q;
   assign last_code_o   = last_code_q;
   assign last_src_o    = last_src_q;
   assign timeout_err_o = err_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed bench for dac_write_arbiter: a main instance with a behavioural
// SPI master (busy 10 cycles per write) and a second instance with an
// 8-cycle timeout whose SPI ready line is held high.
module tb_dac_write_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        arst_n;
   logic [2:0]  req;
   logic [47:0] code;
   logic        err_clr;
   logic [2:0]  ack;
   logic        busy;
   logic [23:0] sdata;
   logic        wre;
   logic        spi_rdy;
   logic [15:0] lcode;
   logic [1:0]  lsrc;
   logic        err;

   logic        model_en, rdy_force, rdy_model;
   int          mcnt;
   assign spi_rdy = model_en ? rdy_model : rdy_force;

   logic [2:0]  req2;
   logic [47:0] code2;
   logic        err_clr2;
   logic [2:0]  ack2;
   logic        busy2;
   logic [23:0] sdata2;
   logic        wre2;
   logic        rdy2;
   logic [15:0] lcode2;
   logic [1:0]  lsrc2;
   logic        err2;

   int n_chk  = 0;
   int n_pass = 0;
   int ackbad = 0;

   dac_write_arbiter u_dut (
      .clk_i         (clk),
      .arst_ni       (arst_n),
      .req_i         (req),
      .code_i        (code),
      .ack_o         (ack),
      .busy_o        (busy),
      .spi_data_o    (sdata),
      .spi_wre_o     (wre),
      .spi_rdy_i     (spi_rdy),
      .last_code_o   (lcode),
      .last_src_o    (lsrc),
      .timeout_err_o (err),
      .err_clr_i     (err_clr)
   );

   dac_write_arbiter #(
      .TIMEOUT_CYCLES (8)
   ) u_dut_to (
      .clk_i         (clk),
      .arst_ni       (arst_n),
      .req_i         (req2),
      .code_i        (code2),
      .ack_o         (ack2),
      .busy_o        (busy2),
      .spi_data_o    (sdata2),
      .spi_wre_o     (wre2),
      .spi_rdy_i     (rdy2),
      .last_code_o   (lcode2),
      .last_src_o    (lsrc2),
      .timeout_err_o (err2),
      .err_clr_i     (err_clr2)
   );

   // SPI master model: goes busy for 10 cycles after each write strobe.
   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rdy_model <= 1'b1;
         mcnt      <= 0;
      end else if (model_en) begin
         if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) rdy_model <= 1'b1;
         end else if (wre) begin
            rdy_model <= 1'b0;
            mcnt      <= 10;
         end
      end
   end

   // Ack must be at most one-hot and only while busy.
   always @(posedge clk) begin
      if (arst_n && (($countones(ack) > 1) || (ack != 3'b000 && !busy) ||
                     ($countones(ack2) > 1) || (ack2 != 3'b000 && !busy2)))
         ackbad <= ackbad + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_ack(output logic [2:0] got);
      got = 3'b000;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ack !== 3'b000) begin
            got = ack;
            break;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  g;
      logic [2:0]  exp_ack [3];
      logic [15:0] exp_code[3];
      int          nwre;

      arst_n    = 1'b0;
      req       = '0;
      code      = '0;
      err_clr   = 1'b0;
      model_en  = 1'b1;
      rdy_force = 1'b1;
      req2      = '0;
      code2     = '0;
      err_clr2  = 1'b0;
      rdy2      = 1'b1;

      // Reset values
      #12;
      chk("rst_busy",  32'(busy),  32'h0);
      chk("rst_wre",   32'(wre),   32'h0);
      chk("rst_ack",   32'(ack),   32'h0);
      chk("rst_data",  32'(sdata), 32'h000000);
      chk("rst_lcode", 32'(lcode), 32'h0);
      chk("rst_lsrc",  32'(lsrc),  32'h0);
      chk("rst_err",   32'(err),   32'h0);
      @(negedge clk);
      arst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single request from requester 0
      code[15:0] = 16'h1234;
      req        = 3'b001;
      @(negedge clk);
      chk("t1_wre_c1",  32'(wre),   32'h1);
      chk("t1_data",    32'(sdata), 32'h001234);
      chk("t1_busy",    32'(busy),  32'h1);
      @(negedge clk);
      chk("t1_wre_c2",  32'(wre),   32'h0);
      wait_ack(g);
      chk("t1_ack",     32'(g),     32'h1);
      chk("t1_lcode",   32'(lcode), 32'h1234);
      chk("t1_lsrc",    32'(lsrc),  32'h0);
      req = 3'b000;
      @(negedge clk);
      chk("t1_ack_off", 32'(ack),   32'h0);
      chk("t1_idle",    32'(busy),  32'h0);

      // Requester 1 pulses its request for a single cycle
      code[31:16] = 16'hBEEF;
      req         = 3'b010;
      @(negedge clk);
      req = 3'b000;
      chk("drop_wre",   32'(wre),   32'h1);
      chk("drop_data",  32'(sdata), 32'h00BEEF);
      wait_ack(g);
      chk("drop_ack",   32'(g),     32'h2);
      chk("drop_lcode", 32'(lcode), 32'hBEEF);
      chk("drop_lsrc",  32'(lsrc),  32'h1);
      @(negedge clk);

      // SPI master not ready for 20 cycles with requester 2 pending
      model_en    = 1'b0;
      rdy_force   = 1'b0;
      code[47:32] = 16'h0777;
      req         = 3'b100;
      nwre        = 0;
      repeat (20) begin
         @(negedge clk);
         if (wre) nwre++;
      end
      chk("nrdy_no_wre", 32'(nwre), 32'h0);
      chk("nrdy_idle",   32'(busy), 32'h0);
      rdy_force = 1'b1;
      model_en  = 1'b1;
      @(negedge clk);
      chk("nrdy_wre",   32'(wre),   32'h1);
      chk("nrdy_data",  32'(sdata), 32'h000777);
      wait_ack(g);
      chk("nrdy_ack",   32'(g),     32'h4);
      chk("nrdy_lcode", 32'(lcode), 32'h0777);
      chk("nrdy_lsrc",  32'(lsrc),  32'h2);
      req = 3'b000;
      @(negedge clk);

      // Contention: all three held, pointer has wrapped to 0
      code       = {16'hCCCC, 16'hBBBB, 16'hAAAA};
      exp_ack    = '{3'b001, 3'b010, 3'b100};
      exp_code   = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      req        = 3'b111;
      for (int k = 0; k < 3; k++) begin
         wait_ack(g);
         chk($sformatf("rr3_ack%0d", k),  32'(g),     32'(exp_ack[k]));
         chk($sformatf("rr3_data%0d", k), 32'(sdata), 32'(exp_code[k]));
         chk($sformatf("rr3_lsrc%0d", k), 32'(lsrc),  32'(k));
         req = req & ~g;
      end
      @(negedge clk);
      req      = 3'b101;
      exp_ack  = '{3'b001, 3'b100, 3'b000};
      exp_code = '{16'hAAAA, 16'hCCCC, 16'h0000};
      for (int k = 0; k < 2; k++) begin
         wait_ack(g);
         chk($sformatf("rr2_ack%0d", k),   32'(g),     32'(exp_ack[k]));
         chk($sformatf("rr2_lcode%0d", k), 32'(lcode), 32'(exp_code[k]));
         req = req & ~g;
      end
      chk("main_no_err", 32'(err), 32'h0);
      @(negedge clk);

      // Reset asserted while the SPI master is busy with a frame
      code[15:0] = 16'h0F0F;
      req        = 3'b001;
      repeat (5) @(negedge clk);
      chk("mid_in_wait", 32'(busy), 32'h1);
      #1 arst_n = 1'b0;
      #1;
      chk("mid_busy",  32'(busy),  32'h0);
      chk("mid_wre",   32'(wre),   32'h0);
      chk("mid_ack",   32'(ack),   32'h0);
      chk("mid_data",  32'(sdata), 32'h000000);
      chk("mid_lcode", 32'(lcode), 32'h0);
      chk("mid_lsrc",  32'(lsrc),  32'h0);
      req         = 3'b010;
      code[31:16] = 16'h5A5A;
      @(negedge clk);
      arst_n = 1'b1;
      wait_ack(g);
      chk("post_ack",   32'(g),     32'h2);
      chk("post_data",  32'(sdata), 32'h005A5A);
      chk("post_lcode", 32'(lcode), 32'h5A5A);
      chk("post_lsrc",  32'(lsrc),  32'h1);
      req = 3'b000;
      @(negedge clk);

      // Timeout instance: ready stuck high after the write strobe
      code2[15:0] = 16'h4321;
      req2        = 3'b001;
      @(negedge clk);
      chk("to_wre",    32'(wre2),   32'h1);
      repeat (8) @(negedge clk);
      chk("to_err_c9", 32'(err2),   32'h0);
      chk("to_busy9",  32'(busy2),  32'h1);
      chk("to_ack_c9", 32'(ack2),   32'h0);
      @(negedge clk);
      chk("to_ack",    32'(ack2),   32'h1);
      chk("to_err",    32'(err2),   32'h1);
      chk("to_lcode",  32'(lcode2), 32'h0);
      req2 = 3'b000;
      @(negedge clk);
      chk("to_sticky", 32'(err2),   32'h1);
      chk("to_ack_off",32'(ack2),   32'h0);
      err_clr2 = 1'b1;
      @(negedge clk);
      err_clr2 = 1'b0;
      chk("to_clr",    32'(err2),   32'h0);

      // Clear coinciding with a new timeout: set wins
      req2 = 3'b001;
      @(negedge clk);
      repeat (8) @(negedge clk);
      err_clr2 = 1'b1;
      @(negedge clk);
      err_clr2 = 1'b0;
      chk("to2_ack",   32'(ack2),   32'h1);
      chk("to2_err",   32'(err2),   32'h1);
      req2 = 3'b000;
      repeat (2) @(negedge clk);

      chk("ack_onehot", 32'(ackbad), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dac_write_arbiter.md
DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of requesters (0 = wishbone, 1 = ch1 ctl, 2 = ch2 ctl).
REQ-002 SHALL have parameter CODE_WIDTH, default 16: DAC threshold code width.
REQ-003 SHALL have parameter DATA_WIDTH, default 24: SPI frame width.
REQ-004 SHALL have parameter DAC_CMD, default 8'h00: command bits placed above the code.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum wait on the SPI master per phase.
REQ-006 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port arst_ni, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port req_i, input, N_REQ: per-requester write request, level, held until ack.
REQ-009 SHALL have port code_i, input, N_REQ*CODE_WIDTH: packed codes; slice i belongs to req_i[i].
REQ-010 SHALL have port ack_o, output, N_REQ: one-cycle pulse when requester i's frame completes.
REQ-011 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-012 SHALL have port spi_data_o, output, DATA_WIDTH: {DAC_CMD, latched code}, zero-padded between.
REQ-013 SHALL have port spi_wre_o, output, 1: one-cycle write strobe to the SPI master.
REQ-014 SHALL have port spi_rdy_i, input, 1: SPI master ready; high = idle.
REQ-015 SHALL have port last_code_o, output, CODE_WIDTH: last code completed.
REQ-016 SHALL have port last_src_o, output, $clog2(N_REQ): index of the last completed requester.
REQ-017 SHALL have port timeout_err_o, output, 1: sticky timeout flag.
REQ-018 SHALL have port err_clr_i, input, 1: one-cycle clear of timeout_err_o.

Function
REQ-019 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and ACK.
REQ-020 IDLE SHALL go to LAUNCH only when any req_i bit is high and spi_rdy_i=1; otherwise it holds.
REQ-021 On the IDLE->LAUNCH edge, the block SHALL latch the grant index and code_i slice; spi_data_o SHALL hold the latched frame until the next grant.
REQ-022 In LAUNCH, spi_wre_o SHALL be 1 for exactly one cycle, and the FSM SHALL go to WAIT_BUSY.
REQ-023 WAIT_BUSY SHALL go to WAIT_DONE on spi_rdy_i=0.
REQ-024 WAIT_DONE SHALL go to ACK on spi_rdy_i=1.
REQ-025 In ACK, ack_o[grant]=1 for one cycle, last_code_o and last_src_o SHALL update, and the FSM SHALL return to IDLE.
REQ-026 Latency: with a request held from cycle 0, spi_wre_o SHALL be high in cycle 1, and ack SHALL come one cycle after WAIT_DONE sees spi_rdy_i=1.
REQ-027 Arbitration SHALL be round-robin.
  - The pointer resets to 0.
  - The grant is the first asserted req_i at or after the pointer, modulo N_REQ.
  - After a grant, pointer = grant+1, wrapping at N_REQ.
REQ-028 Simultaneous requests SHALL each be served once, in pointer order, with no back-to-back starvation.
REQ-029 A requester that drops req_i before its ack SHALL still have its latched frame completed and acked; this is not an error.
REQ-030 A request re-asserted in the cycle after its ack SHALL be eligible only after the other pending requests, per REQ-027.
REQ-031 Timeout: a per-phase counter runs in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, timeout_err_o SHALL set and the FSM SHALL go to ACK (the requester is acked, not hung).
  - last_code_o SHALL NOT update on a timed-out frame.
REQ-032 If err_clr_i and a new timeout occur in the same cycle, set SHALL win.
REQ-033 Only one ack_o bit SHALL ever be high, and never outside ACK.

Reset
REQ-034 Asserting arst_ni=0 SHALL immediately force the following, including mid-transfer:
  - FSM = IDLE
  - ack_o = 0, busy_o = 0, spi_wre_o = 0
  - spi_data_o = {DAC_CMD, zeros}
  - last_code_o = 0, last_src_o = 0
  - timeout_err_o = 0
  - pointer = 0, timeout counter = 0
REQ-035 After release, the first grant SHALL require spi_rdy_i=1 (REQ-020); an interrupted frame SHALL NOT be retried.

Structure
REQ-036 The shared package measure_pkg SHALL hold DAC_CODE_WIDTH=16, DAC_DATA_WIDTH=24, DAC_CMD and the enum dac_arb_state_t.
REQ-037 Round-robin selection SHALL be the sub-module rr_arbiter.
  - Inputs: req, pointer.
  - Outputs: grant index, valid.
  - Purely combinational.
REQ-038 The FSM, latches, timeout counter and flags SHALL live in dac_write_arbiter; target 150-300 lines total.

Verification
REQ-039 Single request: req_i=3'b001, code=16'h1234, SPI model busy 10 cycles -> spi_wre_o high in cycle 1, spi_data_o=24'h001234, ack_o=3'b001 once, last_code_o=16'h1234, last_src_o=0.
REQ-040 Contention: req_i=3'b111 held with codes A/B/C -> frames in order 0,1,2, three acks, pointer wraps to 0; re-assert 3'b101 -> order 0,2.
REQ-041 SPI not ready: spi_rdy_i=0 for 20 cycles with req_i[2]=1 -> no spi_wre_o until spi_rdy_i=1, then normal completion.
REQ-042 Timeout: TIMEOUT_CYCLES=8, spi_rdy_i stuck high after spi_wre_o -> timeout_err_o=1 after 8 cycles in WAIT_BUSY, ack pulsed, last_code_o unchanged; err_clr_i -> 0.
REQ-043 Reset mid-frame: arst_ni low during WAIT_DONE -> all outputs at reset values the same cycle; after release with req_i=3'b010 -> grant 1, code re-latched.
REQ-044 Dropped request: req_i[1] pulsed for one cycle with code 16'hBEEF -> frame 24'h00BEEF completes, ack_o[1] pulses.
